// File: rtl/period_meter.sv
// Period meter: measures clk cycles between synchronized rising edges of sig_in.
// Optional macro PERIOD_METER_HIGH_TIME_EN adds the high_time output.
module period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             lost,
    output logic             timeout
`ifdef PERIOD_METER_HIGH_TIME_EN
    ,
    output logic [CNT_W-1:0] high_time
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    logic                   r_edge;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_load;
    logic                   w_timeout;
    logic                   w_xfer;
    logic [CNT_W-1:0]       r_period;
    logic                   r_valid;
    logic                   r_lost;
    logic                   r_timeout;

    // Edge pulse is registered so the latency from sig_in to result is fixed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
            r_edge   <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_sync_d <= r_sync[SYNC_STAGES-1];
            r_edge   <= r_sync[SYNC_STAGES-1] & ~r_sync_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_timeout   = 1'b0;
        if (!en) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_cnt_nxt = '0;
                    if (r_edge) begin
                        w_state_nxt = MEASURE;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
                MEASURE: begin
                    // An edge coinciding with saturation still yields a result.
                    if (r_edge) begin
                        w_load    = 1'b1;
                        w_cnt_nxt = CNT_W'(1);
                    end else if (r_cnt == CNT_MAX) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign w_xfer = r_valid & period_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_lost    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout;
            if (w_load) begin
                r_period <= r_cnt;
            end
            if (w_load) begin
                r_valid <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
            if (w_load && r_valid && !w_xfer) begin
                r_lost <= 1'b1;
            end else if (w_xfer && !w_load) begin
                r_lost <= 1'b0;
            end
        end
    end

`ifdef PERIOD_METER_HIGH_TIME_EN
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_high_time;

    // r_sync_d is aligned with r_edge, so the window matches the period count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hcnt      <= '0;
            r_high_time <= '0;
        end else begin
            if (w_load) begin
                r_high_time <= r_hcnt;
            end
            if (w_state_nxt != MEASURE) begin
                r_hcnt <= '0;
            end else if (r_edge) begin
                r_hcnt <= CNT_W'(1);
            end else if (r_hcnt != CNT_MAX) begin
                r_hcnt <= r_hcnt + {{(CNT_W-1){1'b0}}, r_sync_d};
            end
        end
    end

    assign high_time = r_high_time;
`endif

    assign period       = r_period;
    assign period_valid = r_valid;
    assign lost         = r_lost;
    assign timeout      = r_timeout;

endmodule
